// File: rtl/ahb_sub_pkg.sv
// Shared types and helpers for the AHB subordinate memory: bus encodings,
// responder state encoding and the byte-lane mask helper.
package ahb_sub_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahb_sub_state_e;

  localparam int MAX_LANES = 8;

  // Lanes touched by a transfer of 2**hsize bytes starting at addr_lsbs.
  // Sizes wider than the widest supported bus are rejected before use.
  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [2:0] addr_lsbs,
                                                     input logic [2:0] hsize);
    logic [15:0] m;
    if (hsize > 3'd3) begin
      m = 16'h00FF;
    end else begin
      m = ((16'd1 << (5'd1 << hsize)) - 16'd1) << addr_lsbs;
    end
    return m[MAX_LANES-1:0];
  endfunction

endpackage

// File: rtl/ahb_sub_ram.sv
// Single-port word memory with per-byte write enables and asynchronous read.
// Contents are deliberately not reset.
module ahb_sub_ram #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32,
  localparam int BYTES     = DATA_WIDTH / 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic [BYTES-1:0]      we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (we[b]) begin
        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sub_mem.sv
// AHB subordinate fronting a byte-enabled memory, with programmable wait
// states and the two-cycle ERROR response for illegal transfers.
module ahb_sub_mem
  import ahb_sub_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    hsel,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic                    hreadyout,
  output logic                    hresp,
  output logic [2:0]              st_dbg
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(BYTES);
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);

  ahb_sub_state_e        st_q, st_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q;
  logic                  wr_q;
  logic [BYTES-1:0]      lane_q;

  logic                  accept;
  logic                  take_ok;
  logic                  addr_err;
  logic [7:0]            size_mask;
  logic [BYTES-1:0]      lanes_d;
  logic [BYTES-1:0]      ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign accept = hsel && hready &&
                  (htrans_e'(htrans) == HTRANS_NONSEQ || htrans_e'(htrans) == HTRANS_SEQ);

  assign size_mask = (8'd1 << hsize) - 8'd1;
  assign addr_err  = ({1'b0, haddr} >= SPAN) ||
                     ((haddr[7:0] & size_mask) != 8'd0) ||
                     (hsize > 3'(ADDR_LSB));
  assign lanes_d   = BYTES'(lane_mask(3'(haddr[ADDR_LSB-1:0]), hsize));

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    take_ok = 1'b0;
    case (st_q)
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          st_d  = ST_DATA;
          cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: st_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all close a data phase and may start the next.
        st_d = ST_IDLE;
        if (accept) begin
          if (addr_err) begin
            st_d = ST_ERR1;
          end else begin
            take_ok = 1'b1;
            if (WAIT_STATES > 0) begin
              st_d  = ST_WAIT;
              cnt_d = 4'(WAIT_STATES);
            end else begin
              st_d = ST_DATA;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      st_q   <= ST_IDLE;
      cnt_q  <= 4'd0;
      idx_q  <= '0;
      wr_q   <= 1'b0;
      lane_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      if (take_ok) begin
        idx_q  <= haddr[ADDR_LSB +: IDX_W];
        wr_q   <= hwrite;
        lane_q <= lanes_d;
      end
    end
  end

  // A write still in its data phase when reset hits is dropped.
  assign ram_we = (st_q == ST_DATA && wr_q && !hreset) ? (hwstrb & lane_q) : '0;

  ahb_sub_ram #(
    .DEPTH      (MEM_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (hclk),
    .we    (ram_we),
    .addr  (idx_q),
    .wdata (hwdata),
    .rdata (ram_rdata)
  );

  assign hreadyout = !(st_q == ST_WAIT || st_q == ST_ERR1);
  assign hresp     = (st_q == ST_ERR1 || st_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign hrdata    = (st_q == ST_DATA && !wr_q) ? ram_rdata : '0;
  assign st_dbg    = st_q;

endmodule

// File: tb/tb_ahb_sub_mem.sv
// Bench for ahb_sub_mem: three instances (0, 2 and 3 wait states) share the
// manager bus; each transfer selects one of them.
module tb_ahb_sub_mem;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [2:0]  hsel_v;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [3:0]  hwstrb;
  logic        hready;
  int          sel;

  logic [2:0][31:0] rd_v;
  logic [2:0]       ro_v;
  logic [2:0]       resp_v;
  logic [2:0][2:0]  dbg_v;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // clock / reset block
  always #5 hclk = ~hclk;

  assign hready = ro_v[sel];

  ahb_sub_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_v[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hwstrb(hwstrb), .hready(hready),
    .hrdata(rd_v[0]), .hreadyout(ro_v[0]), .hresp(resp_v[0]), .st_dbg(dbg_v[0]));

  ahb_sub_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_ws2 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_v[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hwstrb(hwstrb), .hready(hready),
    .hrdata(rd_v[1]), .hreadyout(ro_v[1]), .hresp(resp_v[1]), .st_dbg(dbg_v[1]));

  ahb_sub_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_v[2]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hwstrb(hwstrb), .hready(hready),
    .hrdata(rd_v[2]), .hreadyout(ro_v[2]), .hresp(resp_v[2]), .st_dbg(dbg_v[2]));

  typedef struct {
    int          s;
    logic        w;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [3:0]  st;
    int          exp_low;
    logic        exp_first;
    logic        exp_resp;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(int s, logic w, logic [31:0] a, logic [2:0] sz,
                              logic [31:0] wd, logic [3:0] st, int low,
                              logic first, logic resp, logic [31:0] rd);
    vec_t v;
    v.s = s; v.w = w; v.a = a; v.sz = sz; v.wd = wd; v.st = st;
    v.exp_low = low; v.exp_first = first; v.exp_resp = resp; v.exp_rd = rd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // driver: one non-pipelined transfer; inputs change 1ns after posedge,
  // outputs sampled on the falling edge
  task automatic do_xfer(input int s, input logic w, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wd, input logic [3:0] st,
                         output int low, output logic first, output logic resp,
                         output logic [31:0] rd, output logic to);
    sel = s;
    hsel_v = 3'b000;
    hsel_v[s] = 1'b1;
    haddr = a; htrans = 2'd2; hwrite = w; hsize = sz;
    @(posedge hclk); #1;
    htrans = 2'd0; hsel_v = 3'b000; hwdata = wd; hwstrb = st;
    low = 0; to = 1'b1; first = 1'b0; resp = 1'b0; rd = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge hclk);
      if (c == 0) first = resp_v[s];
      if (ro_v[s]) begin
        resp = resp_v[s];
        rd = rd_v[s];
        to = 1'b0;
        break;
      end
      low++;
    end
    @(posedge hclk); #1;
  endtask

  initial begin
    int low;
    logic first, resp, to;
    logic [31:0] rd;

    vecs[0]  = mk(0, 1, 32'h010, 3'd2, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0);
    vecs[1]  = mk(0, 0, 32'h010, 3'd2, 32'h0,        4'h0, 0, 0, 0, 32'hDEADBEEF);
    vecs[2]  = mk(0, 1, 32'h011, 3'd0, 32'h0000AB00, 4'hF, 0, 0, 0, 32'h0);
    vecs[3]  = mk(0, 0, 32'h010, 3'd2, 32'h0,        4'h0, 0, 0, 0, 32'hDEADABEF);
    vecs[4]  = mk(0, 0, 32'h400, 3'd2, 32'h0,        4'h0, 1, 1, 1, 32'h0);
    vecs[5]  = mk(0, 1, 32'h012, 3'd2, 32'h12345678, 4'hF, 1, 1, 1, 32'h0);
    vecs[6]  = mk(0, 0, 32'h010, 3'd2, 32'h0,        4'h0, 0, 0, 0, 32'hDEADABEF);
    vecs[7]  = mk(0, 0, 32'h010, 3'd3, 32'h0,        4'h0, 1, 1, 1, 32'h0);
    vecs[8]  = mk(0, 0, 32'h011, 3'd1, 32'h0,        4'h0, 1, 1, 1, 32'h0);
    vecs[9]  = mk(0, 1, 32'h014, 3'd2, 32'h11223344, 4'hF, 0, 0, 0, 32'h0);
    vecs[10] = mk(0, 1, 32'h016, 3'd1, 32'hAAAA5555, 4'hF, 0, 0, 0, 32'h0);
    vecs[11] = mk(0, 1, 32'h014, 3'd1, 32'hFFFFFFFF, 4'hC, 0, 0, 0, 32'h0);
    vecs[12] = mk(0, 0, 32'h014, 3'd2, 32'h0,        4'h0, 0, 0, 0, 32'hAAAA3344);
    vecs[13] = mk(0, 1, 32'h3FC, 3'd2, 32'hA5A50F0F, 4'hF, 0, 0, 0, 32'h0);
    vecs[14] = mk(0, 0, 32'h3FC, 3'd2, 32'h0,        4'h0, 0, 0, 0, 32'hA5A50F0F);
    vecs[15] = mk(0, 0, 32'h3FD, 3'd0, 32'h0,        4'h0, 0, 0, 0, 32'hA5A50F0F);
    vecs[16] = mk(1, 1, 32'h010, 3'd2, 32'hDEADBEEF, 4'hF, 2, 0, 0, 32'h0);
    vecs[17] = mk(1, 0, 32'h010, 3'd2, 32'h0,        4'h0, 2, 0, 0, 32'hDEADBEEF);
    vecs[18] = mk(1, 0, 32'h400, 3'd2, 32'h0,        4'h0, 1, 1, 1, 32'h0);
    vecs[19] = mk(2, 1, 32'h030, 3'd2, 32'hCAFEF00D, 4'hF, 3, 0, 0, 32'h0);
    vecs[20] = mk(2, 0, 32'h030, 3'd2, 32'h0,        4'h0, 3, 0, 0, 32'hCAFEF00D);

    sel = 0; hreset = 1'b1; hsel_v = 3'b000; haddr = '0; htrans = 2'd0;
    hwrite = 1'b0; hsize = 3'd2; hwdata = '0; hwstrb = '0;
    repeat (3) @(posedge hclk);
    #1 hreset = 1'b0;
    @(negedge hclk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d_hreadyout", i), 32'(ro_v[i]), 32'd1);
      check($sformatf("rst%0d_hresp", i), 32'(resp_v[i]), 32'd0);
      check($sformatf("rst%0d_hrdata", i), rd_v[i], 32'd0);
      check($sformatf("rst%0d_state", i), 32'(dbg_v[i]), 32'd0);
    end
    @(posedge hclk); #1;

    for (int i = 0; i < 21; i++) begin
      exp_q.push_back(vecs[i].exp_rd);
      do_xfer(vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].sz, vecs[i].wd, vecs[i].st,
              low, first, resp, rd, to);
      check($sformatf("v%0d_timeout", i), 32'(to), 32'd0);
      check($sformatf("v%0d_low_cycles", i), low, vecs[i].exp_low);
      check($sformatf("v%0d_first_hresp", i), 32'(first), 32'(vecs[i].exp_first));
      check($sformatf("v%0d_final_hresp", i), 32'(resp), 32'(vecs[i].exp_resp));
      check($sformatf("v%0d_hrdata", i), rd, exp_q.pop_front());
    end

    // back-to-back write then read of the same word, no gap between them
    sel = 0; hsel_v = 3'b001;
    haddr = 32'h020; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    haddr = 32'h020; htrans = 2'd2; hwrite = 1'b0;
    hwdata = 32'h55AA55AA; hwstrb = 4'hF;
    @(negedge hclk);
    check("b2b_wr_hreadyout", 32'(ro_v[0]), 32'd1);
    check("b2b_wr_hresp", 32'(resp_v[0]), 32'd0);
    @(posedge hclk); #1;
    htrans = 2'd0; hsel_v = 3'b000; hwdata = '0;
    @(negedge hclk);
    check("b2b_rd_hreadyout", 32'(ro_v[0]), 32'd1);
    check("b2b_rd_hresp", 32'(resp_v[0]), 32'd0);
    check("b2b_rd_hrdata", rd_v[0], 32'h55AA55AA);
    @(posedge hclk); #1;

    // reset during the second wait cycle of a write
    sel = 2; hsel_v = 3'b100;
    haddr = 32'h030; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    htrans = 2'd0; hsel_v = 3'b000; hwdata = 32'h12345678; hwstrb = 4'hF;
    @(negedge hclk);
    check("rstmid_wait1_hreadyout", 32'(ro_v[2]), 32'd0);
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(negedge hclk);
    check("rstmid_wait2_hreadyout", 32'(ro_v[2]), 32'd0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(negedge hclk);
    check("rstmid_hreadyout", 32'(ro_v[2]), 32'd1);
    check("rstmid_hresp", 32'(resp_v[2]), 32'd0);
    check("rstmid_hrdata", rd_v[2], 32'd0);
    check("rstmid_state", 32'(dbg_v[2]), 32'd0);
    @(posedge hclk); #1;

    do_xfer(2, 1'b0, 32'h030, 3'd2, 32'h0, 4'h0, low, first, resp, rd, to);
    check("rstmid_rd_timeout", 32'(to), 32'd0);
    check("rstmid_rd_low_cycles", low, 3);
    check("rstmid_rd_hrdata", rd, 32'hCAFEF00D);
    do_xfer(0, 1'b0, 32'h020, 3'd2, 32'h0, 4'h0, low, first, resp, rd, to);
    check("rst_retain_hrdata", rd, 32'h55AA55AA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
